// File: rtl/start_done_seq.sv
// rtl/start_done_seq.sv - start/done sequencer with Moore/Mealy done, abort, optional queued start
// Optional queued start (one deep) is built when START_PENDING_EN is defined.
module start_done_seq #(
   parameter int CNT_W     = 4,
   parameter int DONE_MODE = 0
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic [CNT_W-1:0] len_q, len_q_nx;
   logic             last;
   logic             accept;

   assign last   = (cnt_q == len_q);
   assign accept = start & ~abort;

`ifdef START_PENDING_EN
   logic             pend_q, pend_nx;
   logic [CNT_W-1:0] len_p, len_p_nx;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt_q;
      len_q_nx = len_q;
      busy     = 1'b0;
      done     = 1'b0;
      count    = '0;
`ifdef START_PENDING_EN
      pend_nx  = pend_q;
      len_p_nx = len_p;
`endif
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = S_RUN;
               cnt_nx   = '0;
               len_q_nx = len;
            end
         end
         S_RUN: begin
            busy  = 1'b1;
            count = cnt_q;
            if (abort) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
`ifdef START_PENDING_EN
               pend_nx  = 1'b0;
`endif
            end else if (!last) begin
               cnt_nx = cnt_q + 1'b1;
`ifdef START_PENDING_EN
               if (start) begin
                  pend_nx  = 1'b1;
                  len_p_nx = len;
               end
`endif
            end else begin
               cnt_nx = '0;
               if (DONE_MODE == 0) begin
                  state_nx = S_DONE;
`ifdef START_PENDING_EN
                  if (start) begin
                     pend_nx  = 1'b1;
                     len_p_nx = len;
                  end
`endif
               end else begin
                  done     = 1'b1;
                  state_nx = S_IDLE;
`ifdef START_PENDING_EN
                  // a start on the terminal cycle is treated as the newest queued one
                  if (pend_q || start) begin
                     state_nx = S_RUN;
                     len_q_nx = start ? len : len_p;
                     pend_nx  = 1'b0;
                  end
`endif
               end
            end
         end
         S_DONE: begin
            done     = 1'b1;
            cnt_nx   = '0;
            state_nx = S_IDLE;
            // a live start wins over both the IDLE return and any queued start
            if (accept) begin
               state_nx = S_RUN;
               len_q_nx = len;
`ifdef START_PENDING_EN
               pend_nx  = 1'b0;
`endif
            end
`ifdef START_PENDING_EN
            else if (abort) begin
               pend_nx = 1'b0;
            end else if (pend_q) begin
               state_nx = S_RUN;
               len_q_nx = len_p;
               pend_nx  = 1'b0;
            end
`endif
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         state <= state_nx;
         cnt_q <= cnt_nx;
         len_q <= len_q_nx;
      end
   end

`ifdef START_PENDING_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         len_p  <= '0;
      end else begin
         pend_q <= pend_nx;
         len_p  <= len_p_nx;
      end
   end
`endif

endmodule

// File: tb/tb_start_done_seq.sv
// tb/tb_start_done_seq.sv - scoreboard bench for start_done_seq, Moore and Mealy instances side by side
// Queued-start expectations follow START_PENDING_EN.
module tb_start_done_seq;

   localparam int CNT_W = 4;
   localparam int W     = 28;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             start, abort;
   logic [CNT_W-1:0] len;
   logic             busy_mo, done_mo, busy_me, done_me;
   logic [CNT_W-1:0] count_mo, count_me;

   always #5 clock = ~clock;

   start_done_seq #(.CNT_W(CNT_W), .DONE_MODE(0)) dut_moore (
      .clock(clock), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
      .busy(busy_mo), .done(done_mo), .count(count_mo)
   );

   start_done_seq #(.CNT_W(CNT_W), .DONE_MODE(1)) dut_mealy (
      .clock(clock), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
      .busy(busy_me), .done(done_me), .count(count_me)
   );

   typedef struct packed {
      logic             busy;
      logic [CNT_W-1:0] count;
      logic             done;
   } obs_t;

   obs_t             q_mo[$];
   obs_t             q_me[$];
   obs_t             e_mo[W];
   obs_t             e_me[W];
   logic             st_a[W];
   logic             ab_a[W];
   logic             rs_a[W];
   logic [CNT_W-1:0] ln_a[W];

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_plan();
      for (int i = 0; i < W; i++) begin
         st_a[i] = 1'b0;
         ab_a[i] = 1'b0;
         rs_a[i] = 1'b0;
         ln_a[i] = '0;
         e_mo[i] = '0;
         e_me[i] = '0;
      end
   endtask

   task automatic clear_from(input int c);
      for (int i = c; i < W; i++) begin
         e_mo[i] = '0;
         e_me[i] = '0;
      end
   endtask

   task automatic add_start(input int c, input int l);
      st_a[c] = 1'b1;
      ln_a[c] = l[CNT_W-1:0];
   endtask

   // Run accepted at the edge ending cycle base-1; abort_k >= 0 means abort is driven while count==abort_k.
   task automatic plan_run(input int base, input int l, input int abort_k, input bit do_mo, input bit do_me);
      for (int k = 0; k <= l; k++) begin
         if ((abort_k < 0 || k <= abort_k) && base + k < W) begin
            if (do_mo) begin
               e_mo[base+k].busy  = 1'b1;
               e_mo[base+k].count = k[CNT_W-1:0];
            end
            if (do_me) begin
               e_me[base+k].busy  = 1'b1;
               e_me[base+k].count = k[CNT_W-1:0];
            end
         end
      end
      if (abort_k < 0) begin
         if (do_me && base + l < W)     e_me[base+l].done   = 1'b1;
         if (do_mo && base + l + 1 < W) e_mo[base+l+1].done = 1'b1;
      end
   endtask

   task automatic run_window(input string name);
      obs_t em, ee;
      for (int i = 0; i < W; i++) begin
         q_mo.push_back(e_mo[i]);
         q_me.push_back(e_me[i]);
      end
      for (int c = 0; c < W; c++) begin
         @(negedge clock);
         rst_n = ~rs_a[c];
         start = st_a[c];
         abort = ab_a[c];
         len   = ln_a[c];
         #1;
         em = q_mo.pop_front();
         ee = q_me.pop_front();
         check($sformatf("%s moore busy c%0d", name, c), busy_mo, em.busy);
         check($sformatf("%s moore count c%0d", name, c), count_mo, em.count);
         check($sformatf("%s moore done c%0d", name, c), done_mo, em.done);
         check($sformatf("%s mealy busy c%0d", name, c), busy_me, ee.busy);
         check($sformatf("%s mealy count c%0d", name, c), count_me, ee.count);
         check($sformatf("%s mealy done c%0d", name, c), done_me, ee.done);
      end
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      len   = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      len   = '0;
      #2;
      check("reset moore busy", busy_mo, 0);
      check("reset moore count", count_mo, 0);
      check("reset moore done", done_mo, 0);
      check("reset mealy busy", busy_me, 0);
      check("reset mealy count", count_me, 0);
      check("reset mealy done", done_me, 0);
      #8 rst_n = 1'b1;
      #1;

      // len=3, abort during Moore DONE must not disturb done
      clear_plan();
      add_start(1, 3);
      plan_run(2, 3, -1, 1, 1);
      ab_a[6] = 1'b1;
      run_window("len3");

      // shortest and longest runs
      clear_plan();
      add_start(1, 0);
      plan_run(2, 0, -1, 1, 1);
      add_start(4, 15);
      plan_run(5, 15, -1, 1, 1);
      run_window("len0_len15");

      // abort at count 2, then a fresh run
      clear_plan();
      add_start(1, 5);
      plan_run(2, 5, 2, 1, 1);
      ab_a[4] = 1'b1;
      add_start(6, 2);
      plan_run(7, 2, -1, 1, 1);
      run_window("abort");

      // start on the Moore DONE cycle: back-to-back run
      clear_plan();
      add_start(1, 2);
      plan_run(2, 2, -1, 1, 1);
      add_start(5, 1);
      plan_run(6, 1, -1, 1, 1);
      run_window("b2b");

      // reset in the middle of a run, then a normal run
      clear_plan();
      add_start(1, 6);
      plan_run(2, 6, -1, 1, 1);
      rs_a[5] = 1'b1;
      clear_from(5);
      add_start(8, 1);
      plan_run(9, 1, -1, 1, 1);
      run_window("midreset");

      // second start at count 1 while running
      clear_plan();
      add_start(1, 2);
      plan_run(2, 2, -1, 1, 1);
      add_start(3, 1);
`ifdef START_PENDING_EN
      plan_run(5, 1, -1, 0, 1);
      plan_run(6, 1, -1, 1, 0);
`endif
      run_window("pending");

      // same, aborted on the final run cycle: no done, no second run
      clear_plan();
      add_start(1, 2);
      plan_run(2, 2, 2, 1, 1);
      add_start(3, 1);
      ab_a[4] = 1'b1;
      run_window("pend_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
